instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch stage directly downstream of the 12-bit program counter. Reads the counter value, issues a read to program memory and tolerates any number of memory wait states. Latches the returned word into a one-entry instruction register with a valid/ready handshake toward decode. Pulses the counter's `increment` input once per accepted word, and discards in-flight fetches on a branch flush.

## Interface
Parameters:
- `ADDR_W`, 12: program address width; matches the PC.
- `INSTR_W`, 16: instruction word width.
- `TIMEOUT_CYCLES`, 255: wait-state limit. Used only with `FETCH_TIMEOUT_EN`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `pc`, input, ADDR_W: current PC value (`Q` of the PC).
- `pc_increment`, output, 1: one-cycle pulse to the PC `increment` input.
- `hold`, input, 1: blocks issue of new fetches.
- `flush`, input, 1: branch taken; the PC is loaded in this same cycle.
- `mem_rd`, output, 1: memory read request.
- `mem_addr`, output, ADDR_W: read address.
- `mem_ready`, input, 1: memory data valid this cycle.
- `mem_data`, input, INSTR_W: read data.
- `ir`, output, INSTR_W: instruction register.
- `ir_pc`, output, ADDR_W: address `ir` was fetched from.
- `ir_valid`, output, 1: `ir` holds an unconsumed word.
- `ir_ready`, input, 1: decode accepts `ir` this cycle.
- `fetch_err`, output, 1: sticky timeout flag.

## Operation
States: IDLE, FETCH, WAIT, DRAIN, ERR.

- **Reset:** state IDLE.
  - `ir`, `ir_pc`, `req_addr` = 0.
  - `ir_valid`, `mem_rd`, `pc_increment`, `fetch_err` = 0.
- **IDLE:** moves to FETCH on the next cycle unconditionally.
- **can_issue** = `!hold && !flush && (!ir_valid || ir_ready)`.
- **FETCH:**
  - `mem_rd` = can_issue; `mem_addr` = `pc`.
  - When `mem_rd` is high, `req_addr` ← `pc`.
  - `mem_rd && mem_ready` (capture):
    - `ir` ← `mem_data`, `ir_pc` ← `pc`, `ir_valid` ← 1.
    - `pc_increment` = 1 this cycle.
    - Stay in FETCH.
  - `mem_rd && !mem_ready`: go to WAIT.
- **WAIT:**
  - `mem_rd` = 1; `mem_addr` = `req_addr`. `hold` does not drop the request.
  - On `mem_ready`: capture as above using `req_addr`, then return to FETCH.
  - `ir` is guaranteed empty here: issue required IR empty or consumed.
- **DRAIN:**
  - Entered from WAIT on `flush`.
  - `mem_rd` = 1 and `mem_addr` = `req_addr` until `mem_ready`.
  - The data is discarded, with no `pc_increment`, then return to FETCH.
- **Flush:**
  - `ir_valid` ← 0 next edge.
  - `pc_increment` is forced 0 in any cycle `flush` = 1. The PC gives increment priority over load, so the branch target would otherwise be lost.
  - Flush in FETCH issues nothing that cycle.
- **Handshake:**
  - Decode transfer when `ir_valid && ir_ready`.
  - If no capture occurs in that cycle, `ir_valid` ← 0.
  - Capture and consume in the same cycle leaves `ir_valid` = 1 with the new word.
- **Address width:** `req_addr` is a plain ADDR_W register. The wrap from 0xFFF to 0x000 is the PC's behaviour; no special case here.

## Timing
- Zero-wait memory with `ir_ready` = 1: one word per cycle. `ir` is valid 1 cycle after `mem_rd` is asserted.
- N wait states: capture on cycle N+1 of the request; `mem_addr` stable throughout.
- `pc_increment` is combinational, coincident with capture. The PC shows the next address on the following cycle.
- `mem_rd` is never deasserted before `mem_ready` once raised, except on timeout.
- `hold` or `!ir_ready` with IR full: `mem_rd` = 0 and `pc_increment` = 0. Outputs are held.
- `reset` mid-WAIT: returns to IDLE next edge; the pending memory response is ignored.

## Configuration
- **`FETCH_TIMEOUT_EN` defined:**
  - An 8+ bit counter runs in WAIT and DRAIN and clears on state entry.
  - On reaching `TIMEOUT_CYCLES` without `mem_ready`: `mem_rd` ← 0, `fetch_err` ← 1, state ERR.
  - ERR holds until `reset`; no further fetches.
- **Not defined:** no counter; `fetch_err` is tied 0, ERR is unreachable, and waits are unbounded.

## Test plan
- **Reset, then zero-wait stream:**
  - Stimulus: `reset` 2 cycles; PC model from 0x000; memory returns 0xA000+addr; `mem_ready` = 1, `ir_ready` = 1.
  - Response: `ir` = 0xA000, 0xA001, 0xA002 on consecutive cycles; `ir_pc` = 0x000..0x002; one `pc_increment` per word.
- **Wait states:**
  - Stimulus: `mem_ready` delayed 3 cycles for address 0x010.
  - Response: `mem_rd` high 4 cycles with `mem_addr` = 0x010 stable; single `pc_increment` in the 4th cycle.
- **Backpressure:**
  - Stimulus: `ir_ready` = 0 with `ir_valid` = 1 for 5 cycles.
  - Response: `mem_rd` = 0 and `ir` unchanged. On `ir_ready` = 1, a new fetch is issued the same cycle.
- **Flush during WAIT:**
  - Stimulus: `flush` with PC loaded to 0x200.
  - Response: DRAIN discards the old word; no `pc_increment` in the flush cycle; the next `ir_pc` = 0x200.
- **Timeout, with `FETCH_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8:**
  - Stimulus: `mem_ready` never asserted.
  - Response: `fetch_err` = 1 after 8 WAIT cycles; `mem_rd` = 0 until `reset`.
- **Wrap:**
  - Stimulus: PC = 0xFFF.
  - Response: capture with `ir_pc` = 0xFFF; the next fetch address is 0x000.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetch stage behind the 12-bit PC. It issues program-memory
//               reads, absorbs wait states, holds a one-entry instruction
//               register for decode and pulses the PC increment. The optional
//               wait-state timeout is enabled by defining FETCH_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter int ADDR_W         = 12,
    parameter int INSTR_W        = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    output logic               pc_increment,
    input  logic               hold,
    input  logic               flush,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ready,
    input  logic [INSTR_W-1:0] mem_data,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic               fetch_err
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FETCH = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_DRAIN = 3'd3;
    localparam logic [2:0] c_ERR   = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [INSTR_W-1:0] r_ir;
    logic [ADDR_W-1:0]  r_ir_pc;
    logic               r_ir_valid;
    logic [ADDR_W-1:0]  r_req_addr;

    logic               w_can_issue;
    logic               w_mem_rd;
    logic [ADDR_W-1:0]  w_mem_addr;
    logic               w_capture;
    logic [ADDR_W-1:0]  w_cap_pc;
    logic               w_timeout;

    assign w_can_issue = !hold && !flush && (!r_ir_valid || ir_ready);

`ifdef FETCH_TIMEOUT_EN
    localparam int c_CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_fetch_err;

    assign w_timeout = ((r_state == c_WAIT) || (r_state == c_DRAIN)) && !mem_ready
                       && (r_wait_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));

    // The count restarts whenever the waiting state is (re)entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt  <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            if (w_next_state != r_state)
                r_wait_cnt <= '0;
            else if ((r_state == c_WAIT) || (r_state == c_DRAIN))
                r_wait_cnt <= r_wait_cnt + 1'b1;
            if (w_timeout)
                r_fetch_err <= 1'b1;
        end
    end

    assign fetch_err = r_fetch_err;
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;

    assign w_timeout = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= c_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  w_next_state = c_FETCH;
            c_FETCH: if (w_mem_rd && !mem_ready) w_next_state = c_WAIT;
            // A response arriving with the flush is simply dropped; no drain is needed.
            c_WAIT: begin
                if (mem_ready)      w_next_state = c_FETCH;
                else if (flush)     w_next_state = c_DRAIN;
                else if (w_timeout) w_next_state = c_ERR;
            end
            c_DRAIN: begin
                if (mem_ready)      w_next_state = c_FETCH;
                else if (w_timeout) w_next_state = c_ERR;
            end
            c_ERR:   w_next_state = c_ERR;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_mem_rd   = 1'b0;
        w_mem_addr = r_req_addr;
        w_capture  = 1'b0;
        w_cap_pc   = r_req_addr;
        case (r_state)
            c_FETCH: begin
                w_mem_rd   = w_can_issue;
                w_mem_addr = pc;
                w_capture  = w_can_issue && mem_ready;
                w_cap_pc   = pc;
            end
            c_WAIT: begin
                w_mem_rd  = 1'b1;
                w_capture = mem_ready && !flush;
            end
            c_DRAIN: w_mem_rd = 1'b1;
            default: w_mem_rd = 1'b0;
        endcase
    end

    // The PC favours increment over load, so a flush must never see an increment.
    assign pc_increment = w_capture && !flush;
    assign mem_rd       = w_mem_rd;
    assign mem_addr     = w_mem_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
            r_req_addr <= '0;
        end else begin
            if ((r_state == c_FETCH) && w_mem_rd)
                r_req_addr <= pc;
            if (w_capture) begin
                r_ir    <= mem_data;
                r_ir_pc <= w_cap_pc;
            end
            if (flush)
                r_ir_valid <= 1'b0;
            else if (w_capture)
                r_ir_valid <= 1'b1;
            else if (r_ir_valid && ir_ready)
                r_ir_valid <= 1'b0;
        end
    end

    assign ir       = r_ir;
    assign ir_pc    = r_ir_pc;
    assign ir_valid = r_ir_valid;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed bench for instruction_fetch_unit with a PC model and
//               a memory returning 0xA000 + address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic [11:0] pc;
    logic        pc_increment;
    logic        hold;
    logic        flush;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_data;
    logic [15:0] ir;
    logic [11:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        fetch_err;

    logic        load_en;
    logic [11:0] load_val;

    int vectors    = 0;
    int miscompares = 0;

    instruction_fetch_unit #(
        .ADDR_W         (12),
        .INSTR_W        (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .pc_increment (pc_increment),
        .hold         (hold),
        .flush        (flush),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_data     (mem_data),
        .ir           (ir),
        .ir_pc        (ir_pc),
        .ir_valid     (ir_valid),
        .ir_ready     (ir_ready),
        .fetch_err    (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter: increment wins over load.
    always @(posedge clk) begin
        if (reset)             pc <= 12'h000;
        else if (pc_increment) pc <= pc + 12'h001;
        else if (load_en)      pc <= load_val;
    end

    assign mem_data = 16'hA000 + {4'h0, mem_addr};

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; hold = 1'b0; flush = 1'b0; mem_ready = 1'b1; ir_ready = 1'b1;
        load_en = 1'b0; load_val = 12'h000;
        step();
        step();
        vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ir_valid: got %b want 0", ir_valid); end
        vectors++; if (ir !== 16'h0000) begin miscompares++; $display("FAIL reset_ir: got %h want 0000", ir); end
        vectors++; if (ir_pc !== 12'h000) begin miscompares++; $display("FAIL reset_ir_pc: got %h want 000", ir_pc); end
        vectors++; if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
        vectors++; if (pc_increment !== 1'b0) begin miscompares++; $display("FAIL reset_pc_inc: got %b want 0", pc_increment); end
        vectors++; if (fetch_err !== 1'b0) begin miscompares++; $display("FAIL reset_fetch_err: got %b want 0", fetch_err); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            vectors++; if (mem_rd !== 1'b1) begin miscompares++; $display("FAIL stream_mem_rd[%0d]: got %b want 1", i, mem_rd); end
            vectors++; if (mem_addr !== 12'(i)) begin miscompares++; $display("FAIL stream_mem_addr[%0d]: got %h want %h", i, mem_addr, 12'(i)); end
            vectors++; if (pc_increment !== 1'b1) begin miscompares++; $display("FAIL stream_pc_inc[%0d]: got %b want 1", i, pc_increment); end
            step();
            vectors++; if (ir !== 16'hA000 + 16'(i)) begin miscompares++; $display("FAIL stream_ir[%0d]: got %h want %h", i, ir, 16'hA000 + 16'(i)); end
            vectors++; if (ir_pc !== 12'(i)) begin miscompares++; $display("FAIL stream_ir_pc[%0d]: got %h want %h", i, ir_pc, 12'(i)); end
            vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("FAIL stream_ir_valid[%0d]: got %b want 1", i, ir_valid); end
        end
    endtask

    task automatic test_backpressure();
        ir_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++; if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL bp_mem_rd[%0d]: got %b want 0", i, mem_rd); end
            vectors++; if (pc_increment !== 1'b0) begin miscompares++; $display("FAIL bp_pc_inc[%0d]: got %b want 0", i, pc_increment); end
            vectors++; if (ir !== 16'hA002 || ir_valid !== 1'b1) begin miscompares++; $display("FAIL bp_ir[%0d]: got %h/%b want A002/1", i, ir, ir_valid); end
            step();
        end
        ir_ready = 1'b1;
        #1;
        vectors++; if (mem_rd !== 1'b1 || mem_addr !== 12'h003) begin miscompares++; $display("FAIL bp_release_issue: got %b@%h want 1@003", mem_rd, mem_addr); end
        vectors++; if (pc_increment !== 1'b1) begin miscompares++; $display("FAIL bp_release_pc_inc: got %b want 1", pc_increment); end
        step();
        vectors++; if (ir !== 16'hA003 || ir_pc !== 12'h003) begin miscompares++; $display("FAIL bp_release_ir: got %h@%h want A003@003", ir, ir_pc); end
    endtask

    task automatic branch_in_fetch(input logic [11:0] target);
        flush = 1'b1; load_en = 1'b1; load_val = target;
        #1;
        vectors++; if (mem_rd !== 1'b0 || pc_increment !== 1'b0) begin miscompares++; $display("FAIL flush_fetch_quiet: got rd=%b inc=%b want 0/0", mem_rd, pc_increment); end
        step();
        flush = 1'b0; load_en = 1'b0;
        #1;
        vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL flush_fetch_ir_valid: got %b want 0", ir_valid); end
    endtask

    task automatic test_wait_states();
        branch_in_fetch(12'h010);
        for (int k = 1; k <= 4; k++) begin
            mem_ready = (k == 4);
            hold = (k == 2 || k == 3);
            #1;
            vectors++; if (mem_rd !== 1'b1 || mem_addr !== 12'h010) begin miscompares++; $display("FAIL wait_req[%0d]: got %b@%h want 1@010", k, mem_rd, mem_addr); end
            vectors++; if (pc_increment !== (k == 4)) begin miscompares++; $display("FAIL wait_pc_inc[%0d]: got %b want %b", k, pc_increment, (k == 4)); end
            step();
        end
        hold = 1'b0;
        vectors++; if (ir !== 16'hA010 || ir_pc !== 12'h010 || ir_valid !== 1'b1) begin miscompares++; $display("FAIL wait_capture: got %h@%h v=%b want A010@010 v=1", ir, ir_pc, ir_valid); end
        hold = 1'b1;
        #1;
        vectors++; if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL hold_mem_rd: got %b want 0", mem_rd); end
        hold = 1'b0;
    endtask

    task automatic test_flush_wait();
        mem_ready = 1'b0;
        #1;
        vectors++; if (mem_rd !== 1'b1 || mem_addr !== 12'h011) begin miscompares++; $display("FAIL fw_issue: got %b@%h want 1@011", mem_rd, mem_addr); end
        step();
        vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL fw_consumed: got %b want 0", ir_valid); end
        flush = 1'b1; load_en = 1'b1; load_val = 12'h200;
        #1;
        vectors++; if (pc_increment !== 1'b0) begin miscompares++; $display("FAIL fw_flush_pc_inc: got %b want 0", pc_increment); end
        step();
        flush = 1'b0; load_en = 1'b0;
        #1;
        vectors++; if (mem_rd !== 1'b1 || mem_addr !== 12'h011) begin miscompares++; $display("FAIL fw_drain_hold: got %b@%h want 1@011", mem_rd, mem_addr); end
        step();
        mem_ready = 1'b1;
        #1;
        vectors++; if (mem_rd !== 1'b1 || pc_increment !== 1'b0) begin miscompares++; $display("FAIL fw_drain_discard: got rd=%b inc=%b want 1/0", mem_rd, pc_increment); end
        step();
        vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL fw_no_capture: got %b want 0", ir_valid); end
        vectors++; if (mem_addr !== 12'h200 || pc_increment !== 1'b1) begin miscompares++; $display("FAIL fw_target_issue: got %h inc=%b want 200/1", mem_addr, pc_increment); end
        step();
        vectors++; if (ir !== 16'hA200 || ir_pc !== 12'h200) begin miscompares++; $display("FAIL fw_target_ir: got %h@%h want A200@200", ir, ir_pc); end
    endtask

    task automatic test_wrap();
        branch_in_fetch(12'hFFF);
        vectors++; if (mem_addr !== 12'hFFF || pc_increment !== 1'b1) begin miscompares++; $display("FAIL wrap_issue: got %h inc=%b want FFF/1", mem_addr, pc_increment); end
        step();
        vectors++; if (ir !== 16'hAFFF || ir_pc !== 12'hFFF) begin miscompares++; $display("FAIL wrap_ir: got %h@%h want AFFF@FFF", ir, ir_pc); end
        vectors++; if (mem_addr !== 12'h000) begin miscompares++; $display("FAIL wrap_next_addr: got %h want 000", mem_addr); end
        step();
        vectors++; if (ir !== 16'hA000 || ir_pc !== 12'h000) begin miscompares++; $display("FAIL wrap_after: got %h@%h want A000@000", ir, ir_pc); end
    endtask

    task automatic test_reset_mid_wait();
        mem_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        vectors++; if (mem_rd !== 1'b0 || ir_valid !== 1'b0 || ir !== 16'h0000) begin miscompares++; $display("FAIL mid_wait_reset: got rd=%b v=%b ir=%h want 0/0/0000", mem_rd, ir_valid, ir); end
        step();
        vectors++; if (mem_rd !== 1'b1 || mem_addr !== 12'h000) begin miscompares++; $display("FAIL mid_wait_restart: got %b@%h want 1@000", mem_rd, mem_addr); end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_ready = 1'b0;
        step();
        step();
        for (int k = 1; k <= 8; k++) begin
            vectors++; if (mem_rd !== 1'b1 || fetch_err !== 1'b0) begin miscompares++; $display("FAIL to_waiting[%0d]: got rd=%b err=%b want 1/0", k, mem_rd, fetch_err); end
            step();
        end
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++; if (mem_rd !== 1'b0 || fetch_err !== 1'b1) begin miscompares++; $display("FAIL to_err[%0d]: got rd=%b err=%b want 0/1", k, mem_rd, fetch_err); end
            step();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_wait_states();
        test_flush_wait();
        test_wrap();
        test_reset_mid_wait();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
